// File: rtl/enc16to4_pend_pkg.sv
// Shared definitions for the 16-to-4 pending encoder and the companion
// 4-to-16 one-hot decoder.
//   N_REQ / IDX_W : request width and encoded index width
//   state_t       : encoder FSM states
//   prio_sel      : priority pick over a request vector (LSB or MSB wins)
//   onehot        : decoder function, index -> one-hot vector
package enc16to4_pend_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Returns the winning index; 0 when vec is empty (caller checks for nonzero).
  function automatic logic [IDX_W-1:0] prio_sel(input logic [N_REQ-1:0] vec,
                                                input logic             lsb_first);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (lsb_first) begin
      // Walk downwards so the lowest set bit is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/enc16to4_pend_prio_enc16.sv
// Combinational 16-input priority encoder.
//   vec : request vector
//   idx : index of the winning bit (LSB_FIRST selects lowest or highest)
//   any : vec is nonzero, idx is meaningful
module prio_enc16
  import enc16to4_pend_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  assign idx = prio_sel(vec, LSB_FIRST);
  assign any = |vec;

endmodule

// File: rtl/enc16to4_pend.sv
// Pending-request encoder: collects request pulses into a pending vector and
// serves them one index per cycle over a valid/ready port.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : synchronous flush of pending and output state
//   req           : request pulses, ORed into pending
//   out_valid     : out_idx holds a granted index
//   out_ready     : consumer accepts out_idx this cycle
//   out_idx       : encoded index of the granted request
//   pending       : pending vector, excluding the in-flight index
//   merge         : one-cycle pulse, a req hit an already-pending bit
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | nothing on the output, out_valid = 0
// PRESENT | out_idx valid and held until accepted
module enc16to4_pend
  import enc16to4_pend_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             merge
);

  state_t           state;
  logic [N_REQ-1:0] comb;
  logic [IDX_W-1:0] sel;
  logic             comb_any;

  // The in-flight index is not part of pending, so a fresh req for it lands
  // in pending as a re-arm rather than a merge.
  assign comb = pending | req;

  prio_enc16 #(.LSB_FIRST(LSB_FIRST)) u_prio (
    .vec (comb),
    .idx (sel),
    .any (comb_any)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state   <= IDLE;
      out_idx <= '0;
      pending <= '0;
      merge   <= 1'b0;
    end else begin
      merge <= |(req & pending);
      case (state)
        IDLE: begin
          if (comb_any) begin
            out_idx <= sel;
            pending <= comb & ~onehot(sel);
            state   <= PRESENT;
          end else begin
            pending <= '0;
          end
        end
        PRESENT: begin
          if (!out_ready) begin
            pending <= comb;
          end else if (comb_any) begin
            // Back-to-back: the next winner replaces the accepted index.
            out_idx <= sel;
            pending <= comb & ~onehot(sel);
          end else begin
            pending <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == PRESENT);

endmodule
